// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state encoding and width defaults for the PWM fade controller.
package pwm_pkg;

  localparam int DUTY_W_DEF  = 32'd8;
  localparam int DWELL_W_DEF = 32'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } fade_state_e;

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running DUTY_W-bit counter compared against duty to form a registered PWM output.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  logic [DUTY_W-1:0] cnt_r;
  logic              pwm_r;

  // wrapping counter plus registered compare
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r <= {DUTY_W{1'b0}};
      pwm_r <= 1'b0;
    end else begin
      cnt_r <= cnt_r + {{(DUTY_W-1){1'b0}}, 1'b1};
      pwm_r <= (cnt_r < duty);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps duty toward a target in clamped steps every dwell+1 clocks and drives pwm_gen.
// Define PWM_FADE_BREATHE_EN to bounce between the start duty and the target instead of finishing.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DUTY_W-1:0]  target,
  input  logic [DUTY_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [DUTY_W-1:0]  duty,
  output logic               busy,
  output logic               done,
  output logic               pwm
);

  fade_state_e        state_r;
  logic [DUTY_W-1:0]  duty_r;
  logic [DUTY_W-1:0]  target_r;
  logic [DUTY_W-1:0]  step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [DUTY_W-1:0]  step_eff_s;
  logic [DUTY_W:0]    sum_s;
  logic [DUTY_W-1:0]  duty_next_s;
`ifdef PWM_FADE_BREATHE_EN
  logic [DUTY_W-1:0]  origin_r;
`endif

  // next duty value one step toward the latched target, clamped so it never passes it
  always_comb begin
    step_eff_s  = (step_r == {DUTY_W{1'b0}}) ? {{(DUTY_W-1){1'b0}}, 1'b1} : step_r;
    sum_s       = {1'b0, duty_r} + {1'b0, step_eff_s};
    duty_next_s = duty_r;
    if (duty_r < target_r) begin
      if (sum_s >= {1'b0, target_r}) begin
        duty_next_s = target_r;
      end else begin
        duty_next_s = sum_s[DUTY_W-1:0];
      end
    end else if (duty_r > target_r) begin
      if ((duty_r - target_r) <= step_eff_s) begin
        duty_next_s = target_r;
      end else begin
        duty_next_s = duty_r - step_eff_s;
      end
    end else begin
      duty_next_s = duty_r;
    end
  end

  // fade FSM; busy and done are registered views of the state one clock behind
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      duty_r      <= {DUTY_W{1'b0}};
      target_r    <= {DUTY_W{1'b0}};
      step_r      <= {DUTY_W{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
      origin_r    <= {DUTY_W{1'b0}};
`endif
    end else begin
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == DONE) && !stop;
      case (state_r)
        IDLE: begin
          // busy_r still high means the previous fade is only just retiring
          if (start && !stop && !busy_r) begin
            target_r    <= target;
            step_r      <= step;
            dwell_r     <= dwell;
            dwell_cnt_r <= dwell;
`ifdef PWM_FADE_BREATHE_EN
            origin_r    <= duty_r;
`endif
            state_r     <= (target == duty_r) ? DONE : RAMP;
          end else begin
            state_r <= IDLE;
          end
        end
        RAMP: begin
          if (stop) begin
            state_r <= IDLE;
          end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
            dwell_cnt_r <= dwell_cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
          end else begin
            duty_r      <= duty_next_s;
            dwell_cnt_r <= dwell_r;
            if (duty_next_s == target_r) begin
`ifdef PWM_FADE_BREATHE_EN
              target_r <= origin_r;
              origin_r <= target_r;
              state_r  <= RAMP;
`else
              state_r  <= DONE;
`endif
            end else begin
              state_r <= RAMP;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign duty = duty_r;
  assign busy = busy_r;
  assign done = done_r;

  pwm_gen #(
    .DUTY_W (DUTY_W)
  ) u_pwm_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .duty    (duty_r),
    .pwm     (pwm)
  );

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed and randomized fades compared against an arithmetic trajectory model.
module tb_pwm_fade_ctrl;

  localparam int DW = 8;
  localparam int LW = 16;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          stop    = 1'b0;
  logic [DW-1:0] target  = '0;
  logic [DW-1:0] step    = '0;
  logic [LW-1:0] dwell   = '0;
  logic [DW-1:0] duty;
  logic          busy;
  logic          done;
  logic          pwm;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_duty = 0;

  pwm_fade_ctrl #(.DUTY_W(DW), .DWELL_W(LW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .target  (target),
    .step    (step),
    .dwell   (dwell),
    .duty    (duty),
    .busy    (busy),
    .done    (done),
    .pwm     (pwm)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: duty moves one clamped step every (dwell+1) edges; done one edge after arrival.
  task automatic run_fade(input int tgt, input int stp, input int dwl, input bit noise);
    int s;
    int per;
    int cur;
    int done_edge;
    int dq[$];
    s   = (stp == 0) ? 1 : stp;
    per = dwl + 1;
    cur = m_duty;
    done_edge = 0;
    if (tgt == cur) done_edge = 1;
    for (int k = 1; done_edge == 0; k++) begin
      if (k % per == 0) begin
        if (tgt > cur) cur = (cur + s > tgt) ? tgt : cur + s;
        else           cur = (cur - s < tgt) ? tgt : cur - s;
      end
      dq.push_back(cur);
      if (cur == tgt) done_edge = k + 1;
    end
    @(negedge clock);
    start = 1'b1; target = DW'(tgt); step = DW'(stp); dwell = LW'(dwl);
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= done_edge + 1; k++) begin
      @(posedge clock); #1;
      check("fade_duty", duty, (k - 1 < dq.size()) ? dq[k-1] : tgt);
      check("fade_done", done, (k == done_edge) ? 1 : 0);
      check("fade_busy", busy, (k <= done_edge) ? 1 : 0);
      start  = noise && (k < done_edge);
      target = DW'($urandom);
    end
    start  = 1'b0;
    m_duty = tgt;
  endtask

  task automatic count_pwm(input string tag, input int exp);
    int hi;
    hi = 0;
    repeat (2) @(posedge clock);
    for (int i = 0; i < 256; i++) begin
      @(posedge clock); #1;
      hi += int'(pwm);
    end
    check(tag, hi, exp);
  endtask

`ifdef PWM_FADE_BREATHE_EN
  int bseq[4] = '{0, 4, 8, 4};
`endif

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pwm", pwm, 0);
    @(negedge clock);
    reset_n = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
    @(negedge clock);
    start = 1'b1; target = 8'd8; step = 8'd4; dwell = '0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      check("br_duty", duty, bseq[k % 4]);
      check("br_done", done, 0);
    end
    stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    check("br_stop_duty", duty, 8);
    repeat (2) begin
      @(posedge clock); #1;
      check("br_stop_hold", duty, 8);
      check("br_stop_done", done, 0);
    end
    check("br_stop_busy", busy, 0);
    @(negedge clock);
    start = 1'b1; target = 8'd0; step = 8'd4; dwell = '0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("br_down", duty, 4);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("br_rst_duty", duty, 0);
    check("br_rst_busy", busy, 0);
    check("br_rst_done", done, 0);
    check("br_rst_pwm", pwm, 0);
    reset_n = 1'b1;
`else
    count_pwm("pwm_duty0", 0);
    run_fade(10, 4, 2, 1'b0);
    run_fade(0, 0, 0, 1'b1);
    run_fade(64, 8, 1, 1'b0);
    count_pwm("pwm_duty64_a", 64);
    count_pwm("pwm_duty64_b", 64);
    run_fade(250, 31, 0, 1'b0);
    run_fade(255, 16, 3, 1'b0);
    count_pwm("pwm_duty255", 255);
    run_fade(0, 255, 0, 1'b0);

    // stop at duty 40, then a zero-distance fade
    @(negedge clock);
    start = 1'b1; target = 8'd200; step = 8'd10; dwell = '0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      check("stop_ramp", duty, 10 * k);
    end
    stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    check("stop_duty", duty, 40);
    check("stop_done", done, 0);
    repeat (3) begin
      @(posedge clock); #1;
      check("stop_hold", duty, 40);
      check("stop_nodone", done, 0);
    end
    check("stop_busy", busy, 0);
    m_duty = 40;
    run_fade(40, 3, 5, 1'b0);

    // reset in the middle of a fade
    @(negedge clock);
    start = 1'b1; target = 8'd200; step = 8'd5; dwell = '0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock); #1;
      check("mid_ramp", duty, 40 + 5 * k);
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_duty", duty, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pwm", pwm, 0);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      check("mid_rst_quiet", {busy, done, duty}, 0);
    end
    m_duty = 0;

    for (int i = 0; i < 8; i++) begin
      run_fade(int'($urandom_range(0, 255)), int'($urandom_range(0, 48)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
